// File: rtl/smp_lfsr_gen.sv
// ---------------------------------------------------------------------------
// smp_lfsr_gen
// Fibonacci-style LFSR (right shift, feedback into the MSB) with free-run
// mode, counted runs under a small IDLE/RUN/DONE FSM, halt, synchronous
// load, and zero-state lockup recovery.
//
// Parameters
//   WIDTH  LFSR state width (8..64)
//   TAPS   feedback tap mask; bit k set -> state[k] feeds back (bits >= WIDTH ignored)
//   STEPS  single-bit shifts applied per advance (1..WIDTH)
//   SEED   reset / lockup-recovery state (nonzero)
//   CNTW   run-length counter width
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   i_wdata1       value written into the state on i_load
//   i_load         load i_wdata1 (highest priority after rst)
//   i_halt         suppress advance in free-run and RUN
//   i_free         free-run enable while IDLE
//   i_start        start a counted run of i_run_len advances (IDLE only)
//   i_run_len      advance count for the run
//   i_clr_lockup   clear the sticky lockup flag
//   o_rdata1       current LFSR state
//   o_adv          pulse the cycle after each advance
//   o_busy         high while in RUN
//   o_done         one-cycle pulse at the end of a counted run
//   o_remain       advances remaining in the current run
//   o_lockup       sticky: an advance from the all-zero state was recovered
// ---------------------------------------------------------------------------
module smp_lfsr_gen #(
    parameter int unsigned WIDTH = 56,
    parameter logic [63:0] TAPS  = 64'h600003,
    parameter int unsigned STEPS = 1,
    parameter logic [63:0] SEED  = 64'd1,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_wdata1,
    input  logic             i_load,
    input  logic             i_halt,
    input  logic             i_free,
    input  logic             i_start,
    input  logic [CNTW-1:0]  i_run_len,
    input  logic             i_clr_lockup,
    output logic [WIDTH-1:0] o_rdata1,
    output logic             o_adv,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNTW-1:0]  o_remain,
    output logic             o_lockup
);

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t             fsm_q,    fsm_d;
    logic [WIDTH-1:0] state_q,  state_d;
    logic [CNTW-1:0]  remain_q, remain_d;
    logic             lockup_q, lockup_d;
    logic             adv_q,    adv_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] stepped;
    logic             do_adv;
    logic             recover;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ^(s & TAP_MASK);
        return {fb, s[WIDTH-1:1]};
    endfunction

    // STEPS single shifts chained combinationally; one advance per clock.
    always_comb begin
        stepped = state_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            stepped = shift1(stepped);
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        remain_d = remain_q;
        lockup_d = lockup_q;
        do_adv   = 1'b0;
        recover  = 1'b0;

        if (i_load) begin
            // Load overrides everything: no advance, no count, FSM frozen.
            state_d  = i_wdata1;
            lockup_d = 1'b0;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_run_len != '0) begin
                            fsm_d    = S_RUN;
                            remain_d = i_run_len;
                        end else begin
                            fsm_d    = S_DONE;
                        end
                    end else if (i_free && !i_halt) begin
                        do_adv = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!i_halt) begin
                        do_adv   = 1'b1;
                        remain_d = remain_q - CNTW'(1);
                        if (remain_q == CNTW'(1)) begin
                            fsm_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    fsm_d = S_IDLE;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase

            recover = do_adv && (state_q == '0);

            // Clear is applied first so a same-cycle recovery leaves it set.
            if (i_clr_lockup) begin
                lockup_d = 1'b0;
            end
            if (do_adv) begin
                if (recover) begin
                    state_d  = SEED_W;
                    lockup_d = 1'b1;
                end else begin
                    state_d  = stepped;
                end
            end
        end

        adv_d  = do_adv;
        busy_d = (fsm_d == S_RUN);
        done_d = (fsm_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            state_q  <= SEED_W;
            remain_q <= '0;
            lockup_q <= 1'b0;
            adv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            remain_q <= remain_d;
            lockup_q <= lockup_d;
            adv_q    <= adv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_rdata1 = state_q;
    assign o_adv    = adv_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_remain = remain_q;
    assign o_lockup = lockup_q;

endmodule

// File: tb/tb_smp_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_smp_lfsr_gen
// Directed, table-driven bench for smp_lfsr_gen at default parameters,
// plus a STEPS=2 instance and hand-written halt / reset-abort sequences.
// ---------------------------------------------------------------------------
module tb_smp_lfsr_gen;

    localparam int unsigned W = 56;
    localparam int unsigned C = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] wdata = '0;
    logic         load = 1'b0, halt = 1'b0, free = 1'b0, start = 1'b0, clr = 1'b0;
    logic [C-1:0] run_len = '0;

    logic [W-1:0] rdata;
    logic         adv, busy, done, lockup;
    logic [C-1:0] remain;

    logic         free2 = 1'b0;
    logic [W-1:0] rdata2;
    logic         adv2, busy2, done2, lockup2;
    logic [C-1:0] remain2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smp_lfsr_gen #(.WIDTH(W), .TAPS(64'h600003), .STEPS(1), .SEED(64'd1), .CNTW(C)) u_dut (
        .clk(clk), .rst(rst), .i_wdata1(wdata), .i_load(load), .i_halt(halt),
        .i_free(free), .i_start(start), .i_run_len(run_len), .i_clr_lockup(clr),
        .o_rdata1(rdata), .o_adv(adv), .o_busy(busy), .o_done(done),
        .o_remain(remain), .o_lockup(lockup)
    );

    smp_lfsr_gen #(.WIDTH(W), .TAPS(64'h600003), .STEPS(2), .SEED(64'd1), .CNTW(C)) u_dut2 (
        .clk(clk), .rst(rst), .i_wdata1('0), .i_load(1'b0), .i_halt(1'b0),
        .i_free(free2), .i_start(1'b0), .i_run_len('0), .i_clr_lockup(1'b0),
        .o_rdata1(rdata2), .o_adv(adv2), .o_busy(busy2), .o_done(done2),
        .o_remain(remain2), .o_lockup(lockup2)
    );

    typedef struct {
        logic         ld;
        logic [W-1:0] wd;
        logic         hl, fr, st;
        logic [C-1:0] len;
        logic         cl;
        logic [W-1:0] e_rd;
        logic         e_adv, e_busy, e_done;
        logic [C-1:0] e_rem;
        logic         e_lock;
    } vec_t;

    function automatic vec_t mk(logic ld, logic [W-1:0] wd, logic hl, logic fr, logic st,
                                logic [C-1:0] len, logic cl, logic [W-1:0] e_rd,
                                logic e_adv, logic e_busy, logic e_done,
                                logic [C-1:0] e_rem, logic e_lock);
        vec_t v;
        v.ld = ld; v.wd = wd; v.hl = hl; v.fr = fr; v.st = st; v.len = len; v.cl = cl;
        v.e_rd = e_rd; v.e_adv = e_adv; v.e_busy = e_busy; v.e_done = e_done;
        v.e_rem = e_rem; v.e_lock = e_lock;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; wdata = '0; halt = 1'b0; free = 1'b0; start = 1'b0;
        run_len = '0; clr = 1'b0;
    endtask

    vec_t tv[23];

    initial begin
        int ncyc;
        int nadv;
        bit done_seen;

        // ld  wdata  hl fr st len cl | rdata  adv busy done rem lock
        tv[0]  = mk(0, 0,     0,1,0, 0,0, 56'h80000000000000, 1,0,0, 0,0); // first shift
        tv[1]  = mk(0, 0,     0,0,0, 0,0, 56'h80000000000000, 0,0,0, 0,0); // idle hold
        tv[2]  = mk(1, 'h123, 0,0,0, 0,0, 56'h123,            0,0,0, 0,0); // load
        tv[3]  = mk(0, 0,     0,0,1, 3,0, 56'h123,            0,1,0, 3,0); // start, no advance
        tv[4]  = mk(0, 0,     0,0,0, 0,0, 56'h91,             1,1,0, 2,0);
        tv[5]  = mk(0, 0,     1,0,0, 0,0, 56'h91,             0,1,0, 2,0); // halt freezes
        tv[6]  = mk(0, 0,     0,1,0, 0,0, 56'h80000000000048, 1,1,0, 1,0); // free ignored
        tv[7]  = mk(0, 0,     0,0,1, 5,0, 56'h40000000000024, 1,0,1, 0,0); // start ignored, done
        tv[8]  = mk(0, 0,     0,0,0, 0,0, 56'h40000000000024, 0,0,0, 0,0);
        tv[9]  = mk(1, 0,     0,0,0, 0,0, 56'h0,              0,0,0, 0,0); // load zero
        tv[10] = mk(0, 0,     0,1,0, 0,0, 56'h1,              1,0,0, 0,1); // recovery
        tv[11] = mk(0, 0,     0,1,0, 0,1, 56'h80000000000000, 1,0,0, 0,0); // clear
        tv[12] = mk(1, 0,     0,0,0, 0,0, 56'h0,              0,0,0, 0,0);
        tv[13] = mk(0, 0,     0,1,0, 0,1, 56'h1,              1,0,0, 0,1); // set beats clear
        tv[14] = mk(1, 'h5,   0,0,0, 0,0, 56'h5,              0,0,0, 0,0); // load clears lockup
        tv[15] = mk(0, 0,     0,0,1, 0,0, 56'h5,              0,0,1, 0,0); // zero-length run
        tv[16] = mk(0, 0,     0,1,0, 0,0, 56'h5,              0,0,0, 0,0); // no advance in DONE
        tv[17] = mk(0, 0,     0,1,0, 0,0, 56'h80000000000002, 1,0,0, 0,0);
        tv[18] = mk(1, 0,     0,0,0, 0,0, 56'h0,              0,0,0, 0,0);
        tv[19] = mk(0, 0,     0,0,1, 2,0, 56'h0,              0,1,0, 2,0);
        tv[20] = mk(0, 0,     0,0,0, 0,0, 56'h1,              1,1,0, 1,1); // recovery counts
        tv[21] = mk(0, 0,     0,0,0, 0,0, 56'h80000000000000, 1,0,1, 0,1);
        tv[22] = mk(0, 0,     0,0,0, 0,1, 56'h80000000000000, 0,0,0, 0,0);

        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rdata",  64'(rdata),  64'h1);
        chk("rst_adv",    64'(adv),    64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_done",   64'(done),   64'h0);
        chk("rst_remain", 64'(remain), 64'h0);
        chk("rst_lockup", 64'(lockup), 64'h0);

        // STEPS=2 instance: one advance from SEED
        free2 = 1'b1;
        tick();
        free2 = 1'b0;
        chk("steps2_rdata", 64'(rdata2), 64'h40000000000000);
        chk("steps2_adv",   64'(adv2),   64'h1);

        for (int i = 0; i < 23; i++) begin
            load = tv[i].ld; wdata = tv[i].wd; halt = tv[i].hl; free = tv[i].fr;
            start = tv[i].st; run_len = tv[i].len; clr = tv[i].cl;
            tick();
            chk($sformatf("v%0d_rdata",  i), 64'(rdata),  64'(tv[i].e_rd));
            chk($sformatf("v%0d_adv",    i), 64'(adv),    64'(tv[i].e_adv));
            chk($sformatf("v%0d_busy",   i), 64'(busy),   64'(tv[i].e_busy));
            chk($sformatf("v%0d_done",   i), 64'(done),   64'(tv[i].e_done));
            chk($sformatf("v%0d_remain", i), 64'(remain), 64'(tv[i].e_rem));
            chk($sformatf("v%0d_lockup", i), 64'(lockup), 64'(tv[i].e_lock));
        end
        idle_inputs();
        tick();

        // Run of 3 with a 4-cycle halt after the first advance
        load = 1'b1; wdata = 'h123;
        tick();
        idle_inputs();
        start = 1'b1; run_len = 3;
        tick();
        idle_inputs();
        ncyc = 0; nadv = 0; done_seen = 0;
        while (ncyc < 30 && !done_seen) begin
            halt = (ncyc >= 1 && ncyc < 5);
            tick();
            ncyc++;
            if (adv) nadv++;
            if (ncyc == 5) begin
                chk("halt_frozen_rdata",  64'(rdata),  64'h91);
                chk("halt_frozen_remain", 64'(remain), 64'h2);
            end
            if (done) done_seen = 1;
        end
        halt = 1'b0;
        chk("halt_done_seen",   64'(done_seen), 64'h1);
        chk("halt_done_cycle",  64'(ncyc),      64'd7);
        chk("halt_adv_count",   64'(nadv),      64'd3);
        chk("halt_final_rdata", 64'(rdata),     64'h40000000000024);
        tick();

        // Reset in the middle of a run of 10 aborts it without o_done
        start = 1'b1; run_len = 10;
        tick();
        idle_inputs();
        repeat (3) tick();
        chk("abort_busy_before", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rdata_async",  64'(rdata),  64'h1);
        chk("abort_busy_async",   64'(busy),   64'h0);
        chk("abort_remain_async", 64'(remain), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_seen = 1;
        end
        chk("abort_no_done", 64'(done_seen), 64'h0);
        chk("abort_rdata",   64'(rdata),     64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/smp_lfsr_gen.md
SMP_LFSR_GEN -- requirements
Module: smp_lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 56, giving the LFSR state width (legal range 8..64).
REQ-002 SHALL have parameter TAPS, default 64'h600003, a feedback tap mask: bit k set means state[k] feeds back; bits at or above WIDTH are ignored.
REQ-003 SHALL have parameter STEPS, default 1, giving the single-bit shifts per advance (legal range 1..WIDTH).
REQ-004 SHALL have parameter SEED, default 1, giving the reset and lockup-recovery state (nonzero).
REQ-005 SHALL have parameter CNTW, default 16, giving the run-length counter width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_wdata1  in  WIDTH  seed value for load.
REQ-009 i_load  in  1  load i_wdata1 into state this cycle.
REQ-010 i_halt  in  1  suppress advance (free-run and RUN).
REQ-011 i_free  in  1  free-run enable while in IDLE.
REQ-012 i_start  in  1  start a counted run (sampled in IDLE only).
REQ-013 i_run_len  in  CNTW  number of advances for the counted run.
REQ-014 i_clr_lockup  in  1  clear sticky lockup flag.
REQ-015 o_rdata1  out  WIDTH  current LFSR state.
REQ-016 o_adv  out  1  high in the cycle after the state advanced.
REQ-017 o_busy  out  1  high while FSM in RUN.
REQ-018 o_done  out  1  one-cycle pulse at the end of a counted run.
REQ-019 o_remain  out  CNTW  advances remaining in the current run.
REQ-020 o_lockup  out  1  sticky flag: zero state was detected and recovered.

Function
REQ-021 Single shift SHALL be fb = XOR of state[k] over TAPS bits k<WIDTH; next = {fb, state[WIDTH-1:1]}.
REQ-022 One advance SHALL apply exactly STEPS single shifts combinationally, with the result registered in one cycle.
REQ-023 Priority SHALL be rst > i_load > i_halt > advance.
REQ-024 i_load SHALL write i_wdata1 in any FSM state, with no advance, no o_remain decrement and no FSM change that cycle, and SHALL clear o_lockup.
REQ-025 FSM states SHALL be IDLE, RUN and DONE.
REQ-026 IDLE: the state SHALL advance each cycle when i_free=1, i_halt=0 and i_load=0.
REQ-027 IDLE with i_start=1 and i_run_len!=0 SHALL go to RUN and set o_remain=i_run_len, with no advance that cycle.
REQ-028 IDLE with i_start=1 and i_run_len==0 SHALL go to DONE without any advance.
REQ-029 RUN: each cycle with i_halt=0 and i_load=0 SHALL advance once and decrement o_remain; the advance that takes o_remain 1->0 SHALL move the FSM to DONE.
REQ-030 RUN with i_halt=1 SHALL freeze both the state and o_remain; i_free and i_start SHALL be ignored in RUN.
REQ-031 DONE SHALL hold for one cycle with o_done=1 and no advance, then return to IDLE.
REQ-032 A run of N SHALL produce exactly N advances, with o_done high N+1 cycles after the start cycle if not halted.
REQ-033 Lockup: an advance from state==0 SHALL load SEED instead of shifting and SHALL set o_lockup; that advance still counts toward o_remain.
REQ-034 o_lockup SHALL clear on i_clr_lockup or i_load; a simultaneous set and clear SHALL leave it set.
REQ-035 o_adv SHALL be a registered pulse, high the cycle after each advance, including recovery advances.
REQ-036 o_busy SHALL be high exactly while FSM==RUN.

Reset
REQ-037 On rst, outputs SHALL be: state=SEED, FSM=IDLE, o_remain=0, o_lockup=0, o_adv=0, o_done=0, o_busy=0.
REQ-038 rst asserted mid-run SHALL abort the run with no o_done pulse.

Verification (defaults WIDTH=56, TAPS=600003h, SEED=1)
REQ-039 Release reset, i_free=1 for 1 cycle -> o_rdata1 goes 1 -> 0x80000000000000, o_adv=1 the next cycle.
REQ-040 STEPS=2, from reset, one advance -> o_rdata1=0x40000000000000.
REQ-041 Load 0x123, i_start with i_run_len=3 -> o_busy high 3 cycles, o_remain 3,2,1,0, o_done pulse once, state equals 3 reference shifts of 0x123.
REQ-042 Mid-run i_halt for 4 cycles -> state and o_remain frozen; total advances still 3 and o_done delayed by 4 cycles.
REQ-043 Load 0 then free-run 1 cycle -> o_rdata1=1 and o_lockup=1; i_clr_lockup -> o_lockup=0.
REQ-044 i_start with i_run_len=0 -> o_done the next cycle with no state change; rst asserted during a run of 10 -> state=SEED, IDLE, no o_done.
